// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector with overlap/non-overlap modes and a saturating match counter.
// Optional per-bit compare mask when SEQ_DETECT_MASK_EN is defined (adds port cfg_mask).
//
// state | meaning
// FILL  | fewer than L valid bits in the history, no compare possible
// HUNT  | history holds L valid bits, compare on every accepted bit
module seq_detect_param #(
   parameter int LEN   = 5,
   parameter int CNT_W = 8,
   parameter int LW    = $clog2(LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LEN-1:0]   cfg_pattern,
   input  logic [LW-1:0]    cfg_len,
   input  logic             cfg_overlap,
   input  logic             cfg_load,
`ifdef SEQ_DETECT_MASK_EN
   input  logic [LEN-1:0]   cfg_mask,
`endif
   input  logic             din_valid,
   input  logic             din,
   input  logic             cnt_clr,
   output logic             seen,
   output logic             armed,
   output logic [CNT_W-1:0] match_count
);

   typedef enum logic {FILL = 1'b0, HUNT = 1'b1} state_t;

   localparam logic [LW-1:0] LEN_LW = LW'(LEN);

   state_t           state_q, state_d;
   logic [LEN-1:0]   pat_q;
   logic [LEN-1:0]   cmp_mask;
   logic [LEN-1:0]   hist_q, hist_d, hist_sh;
   logic [LEN-1:0]   len_mask;
   logic [LW-1:0]    len_q, len_cfg;
   logic [LW-1:0]    fill_q, fill_d, fill_sh;
   logic             ovl_q;
   logic             seen_q, seen_d;
   logic             match;
   logic [CNT_W-1:0] cnt_d;

   // Out-of-range lengths fall back to the full pattern width.
   assign len_cfg = ((cfg_len == '0) || (cfg_len > LEN_LW)) ? LEN_LW : cfg_len;

`ifdef SEQ_DETECT_MASK_EN
   logic [LEN-1:0] mask_q;
   assign cmp_mask = mask_q;
`else
   assign cmp_mask = {LEN{1'b1}};
`endif

   always_comb begin
      state_d  = state_q;
      hist_d   = hist_q;
      fill_d   = fill_q;
      seen_d   = 1'b0;
      cnt_d    = match_count;
      len_mask = '0;
      for (int i = 0; i < LEN; i++) begin
         len_mask[i] = (i < int'(len_q));
      end
      hist_sh = {hist_q[LEN-2:0], din};
      fill_sh = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
      match   = din_valid && !cfg_load && (fill_sh >= len_q) &&
                (((hist_sh ^ pat_q) & len_mask & cmp_mask) == '0);

      if (cfg_load) begin
         state_d = FILL;
         hist_d  = '0;
         fill_d  = '0;
      end else if (din_valid) begin
         hist_d  = hist_sh;
         fill_d  = fill_sh;
         state_d = (fill_sh >= len_q) ? HUNT : FILL;
         if (match) begin
            seen_d = 1'b1;
            // Non-overlap: the completing bit is consumed, restart filling from empty.
            if (!ovl_q) begin
               state_d = FILL;
               hist_d  = '0;
               fill_d  = '0;
            end
         end
      end

      if (cnt_clr) begin
         cnt_d = match ? CNT_W'(1) : '0;
      end else if (match && (match_count != {CNT_W{1'b1}})) begin
         cnt_d = match_count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || cfg_load) begin
         pat_q <= cfg_pattern;
         len_q <= len_cfg;
         ovl_q <= cfg_overlap;
`ifdef SEQ_DETECT_MASK_EN
         mask_q <= cfg_mask;
`endif
      end
      if (reset) begin
         state_q     <= FILL;
         hist_q      <= '0;
         fill_q      <= '0;
         seen_q      <= 1'b0;
         match_count <= '0;
      end else begin
         state_q     <= state_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         seen_q      <= seen_d;
         match_count <= cnt_d;
      end
   end

   assign seen  = seen_q;
   assign armed = (state_q == HUNT);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: instance a (LEN=5, CNT_W=8) and instance b (LEN=8, CNT_W=2)
// share one stimulus bus; each scenario checks the instance it targets.
module tb_seq_detect_param;

   logic       clk;
   logic       reset;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       cfg_load;
`ifdef SEQ_DETECT_MASK_EN
   logic [7:0] cfg_mask;
`endif
   logic       din_valid;
   logic       din;
   logic       cnt_clr;

   logic       seen_a, armed_a;
   logic [7:0] count_a;
   logic       seen_b, armed_b;
   logic [1:0] count_b;

   int checks = 0;
   int fails  = 0;

   seq_detect_param #(.LEN(5), .CNT_W(8)) u_a (
      .clk         (clk),
      .reset       (reset),
      .cfg_pattern (cfg_pattern[4:0]),
      .cfg_len     (cfg_len[2:0]),
      .cfg_overlap (cfg_overlap),
      .cfg_load    (cfg_load),
`ifdef SEQ_DETECT_MASK_EN
      .cfg_mask    (cfg_mask[4:0]),
`endif
      .din_valid   (din_valid),
      .din         (din),
      .cnt_clr     (cnt_clr),
      .seen        (seen_a),
      .armed       (armed_a),
      .match_count (count_a)
   );

   seq_detect_param #(.LEN(8), .CNT_W(2)) u_b (
      .clk         (clk),
      .reset       (reset),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_load    (cfg_load),
`ifdef SEQ_DETECT_MASK_EN
      .cfg_mask    (cfg_mask),
`endif
      .din_valid   (din_valid),
      .din         (din),
      .cnt_clr     (cnt_clr),
      .seen        (seen_b),
      .armed       (armed_b),
      .match_count (count_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic do_reset(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      cfg_load    = 1'b0;
      cnt_clr     = 1'b0;
      din_valid   = 1'b0;
      din         = 1'b0;
      reset       = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic bit_in(input logic d);
      din_valid = 1'b1;
      din       = d;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din       = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cfg_pattern = 8'b10101;
      cfg_len     = 4'd0;
      cfg_overlap = 1'b0;
      cfg_load    = 1'b0;
      cnt_clr     = 1'b0;
      reset       = 1'b1;
      din_valid   = 1'b1;
      din         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset     = 1'b0;
      din_valid = 1'b0;
      checks++; if (seen_a !== 1'b0) begin fails++; $display("FAIL reset_seen_a got %b want 0", seen_a); end
      checks++; if (armed_a !== 1'b0) begin fails++; $display("FAIL reset_armed_a got %b want 0", armed_a); end
      checks++; if (count_a !== 8'd0) begin fails++; $display("FAIL reset_count_a got %0d want 0", count_a); end
      checks++; if (armed_b !== 1'b0) begin fails++; $display("FAIL reset_armed_b got %b want 0", armed_b); end
      checks++; if (count_b !== 2'd0) begin fails++; $display("FAIL reset_count_b got %0d want 0", count_b); end
      idle();
      checks++; if (seen_a !== 1'b0 || armed_a !== 1'b0) begin fails++; $display("FAIL reset_idle_a got seen %b armed %b want 0 0", seen_a, armed_a); end
   endtask

   task automatic test_basic();
      logic [4:0] stream = 5'b00101;
      logic [4:0] exp    = 5'b00001;
      do_reset(8'b00101, 4'd5, 1'b0);
      for (int i = 4; i >= 0; i--) begin
         bit_in(stream[i]);
         checks++; if (seen_a !== exp[i]) begin fails++; $display("FAIL basic_seen bit %0d got %b want %b", 5 - i, seen_a, exp[i]); end
         checks++; if (armed_a !== 1'b0) begin fails++; $display("FAIL basic_armed bit %0d got %b want 0", 5 - i, armed_a); end
      end
      checks++; if (count_a !== 8'd1) begin fails++; $display("FAIL basic_count got %0d want 1", count_a); end
      idle();
      checks++; if (seen_a !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got %b want 0", seen_a); end
   endtask

   task automatic test_overlap();
      logic [4:0] stream  = 5'b10101;
      logic [4:0] exp_ov  = 5'b00101;
      logic [4:0] exp_nov = 5'b00100;
      do_reset(8'b101, 4'd3, 1'b1);
      for (int i = 4; i >= 0; i--) begin
         bit_in(stream[i]);
         checks++; if (seen_a !== exp_ov[i]) begin fails++; $display("FAIL overlap_seen bit %0d got %b want %b", 5 - i, seen_a, exp_ov[i]); end
      end
      checks++; if (count_a !== 8'd2) begin fails++; $display("FAIL overlap_count got %0d want 2", count_a); end
      do_reset(8'b101, 4'd3, 1'b0);
      for (int i = 4; i >= 0; i--) begin
         bit_in(stream[i]);
         checks++; if (seen_a !== exp_nov[i]) begin fails++; $display("FAIL nonoverlap_seen bit %0d got %b want %b", 5 - i, seen_a, exp_nov[i]); end
      end
      checks++; if (count_a !== 8'd1) begin fails++; $display("FAIL nonoverlap_count got %0d want 1", count_a); end
   endtask

   task automatic test_len_gap();
      do_reset(8'b10100111, 4'd3, 1'b1);
      bit_in(1'b1);
      bit_in(1'b1);
      checks++; if (seen_b !== 1'b0 || armed_b !== 1'b0) begin fails++; $display("FAIL gap_bit2 got seen %b armed %b want 0 0", seen_b, armed_b); end
      idle();
      checks++; if (seen_b !== 1'b0 || armed_b !== 1'b0) begin fails++; $display("FAIL gap_idle got seen %b armed %b want 0 0", seen_b, armed_b); end
      bit_in(1'b1);
      checks++; if (seen_b !== 1'b1) begin fails++; $display("FAIL gap_seen got %b want 1", seen_b); end
      checks++; if (armed_b !== 1'b1) begin fails++; $display("FAIL gap_armed got %b want 1", armed_b); end
      checks++; if (count_b !== 2'd1) begin fails++; $display("FAIL gap_count got %0d want 1", count_b); end
   endtask

   task automatic test_saturate();
      logic [1:0] exp_cnt [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset(8'b11, 4'd2, 1'b1);
      for (int i = 0; i < 6; i++) begin
         bit_in(1'b1);
         checks++; if (seen_b !== (i > 0)) begin fails++; $display("FAIL sat_seen bit %0d got %b want %b", i + 1, seen_b, (i > 0)); end
         checks++; if (count_b !== exp_cnt[i]) begin fails++; $display("FAIL sat_count bit %0d got %0d want %0d", i + 1, count_b, exp_cnt[i]); end
      end
   endtask

   task automatic test_cnt_clr();
      do_reset(8'b101, 4'd3, 1'b1);
      bit_in(1'b1);
      bit_in(1'b0);
      bit_in(1'b1);
      checks++; if (count_a !== 8'd1) begin fails++; $display("FAIL clr_precount got %0d want 1", count_a); end
      bit_in(1'b0);
      cnt_clr = 1'b1;
      bit_in(1'b1);
      cnt_clr = 1'b0;
      checks++; if (seen_a !== 1'b1) begin fails++; $display("FAIL clr_match_seen got %b want 1", seen_a); end
      checks++; if (count_a !== 8'd1) begin fails++; $display("FAIL clr_with_match got %0d want 1", count_a); end
      cnt_clr = 1'b1;
      idle();
      cnt_clr = 1'b0;
      checks++; if (count_a !== 8'd0) begin fails++; $display("FAIL clr_alone got %0d want 0", count_a); end
   endtask

   task automatic test_cfg_load();
      logic [4:0] stream = 5'b00101;
      logic [4:0] exp    = 5'b00001;
      do_reset(8'b00101, 4'd5, 1'b0);
      bit_in(1'b0);
      bit_in(1'b0);
      bit_in(1'b1);
      bit_in(1'b0);
      cfg_len   = 4'd7;
      cfg_load  = 1'b1;
      din_valid = 1'b1;
      din       = 1'b1;
      @(posedge clk);
      #1;
      cfg_load  = 1'b0;
      din_valid = 1'b0;
      din       = 1'b0;
      checks++; if (seen_a !== 1'b0 || armed_a !== 1'b0) begin fails++; $display("FAIL load_cycle got seen %b armed %b want 0 0", seen_a, armed_a); end
      for (int i = 4; i >= 0; i--) begin
         bit_in(stream[i]);
         checks++; if (seen_a !== exp[i]) begin fails++; $display("FAIL load_refill bit %0d got %b want %b", 5 - i, seen_a, exp[i]); end
      end
      checks++; if (count_a !== 8'd1) begin fails++; $display("FAIL load_count got %0d want 1", count_a); end
   endtask

   task automatic test_reset_mid();
      do_reset(8'b00101, 4'd5, 1'b0);
      bit_in(1'b0);
      bit_in(1'b0);
      bit_in(1'b1);
      bit_in(1'b0);
      do_reset(8'b00101, 4'd5, 1'b0);
      bit_in(1'b1);
      checks++; if (seen_a !== 1'b0) begin fails++; $display("FAIL reset_mid_seen got %b want 0", seen_a); end
   endtask

`ifdef SEQ_DETECT_MASK_EN
   task automatic test_mask();
      logic [4:0] stream = 5'b11010;
      cfg_mask = 8'b11001;
      do_reset(8'b11100, 4'd5, 1'b0);
      for (int i = 4; i >= 0; i--) bit_in(stream[i]);
      checks++; if (seen_a !== 1'b1) begin fails++; $display("FAIL mask_seen got %b want 1", seen_a); end
      cfg_mask = 8'hFF;
      do_reset(8'b11100, 4'd5, 1'b0);
      for (int i = 4; i >= 0; i--) bit_in(stream[i]);
      checks++; if (seen_a !== 1'b0) begin fails++; $display("FAIL mask_full_seen got %b want 0", seen_a); end
   endtask
`endif

   initial begin
`ifdef SEQ_DETECT_MASK_EN
      cfg_mask = 8'hFF;
`endif
      reset       = 1'b1;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      cfg_load    = 1'b0;
      din_valid   = 1'b0;
      din         = 1'b0;
      cnt_clr     = 1'b0;
      test_reset();
      test_basic();
      test_overlap();
      test_len_gap();
      test_saturate();
      test_cnt_clr();
      test_cfg_load();
      test_reset_mid();
`ifdef SEQ_DETECT_MASK_EN
      test_mask();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
